// File: rtl/pipe_pkg.sv
// Shared types and constants for the parametrised pipeline stage register.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_t;

    // Default bubble payload; stages may override via NOP_DATA.
    localparam logic [31:0] PIPE_NOP_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pipe_stage_stats.sv
// Saturating stall/flush counter pair; cleared only by the synchronous active-low reset.
module pipe_stage_stats
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_inc,
    input  logic             flush_inc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}})) begin
            return v + CNT_ONE;
        end else begin
            return v;
        end
    endfunction

    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    // Next counter values with saturation at all-ones.
    always_comb begin
        stall_d = sat_inc(stall_q, stall_inc);
        flush_d = sat_inc(flush_q, flush_inc);
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= {CNT_W{1'b0}};
            flush_q <= {CNT_W{1'b0}};
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer, freeze and flush.
// Optional statistics counters are built when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned           DATA_W   = 32,
    parameter int unsigned           PC_W     = 32,
    parameter logic [DATA_W-1:0]     NOP_DATA = DATA_W'(PIPE_NOP_DEFAULT),
    parameter logic [PC_W-1:0]       PC_RESET = {PC_W{1'b0}},
    parameter int unsigned           CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    if ((CNT_W < 1) || (DATA_W < 1) || (PC_W < 1)) begin : g_bad_param
        $error("pipe_stage_reg: all widths must be at least 1");
    end

    pipe_state_t       state_q, state_d;
    logic [PC_W-1:0]   main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
    logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic              main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic              in_fire_s, out_fire_s;

    // in_ready comes from registered state only, so no path from out_ready.
    assign in_ready   = rst & (state_q != SKID) & ~freeze;
    assign out_valid  = main_valid_q & ~freeze;
    assign out_pc     = main_pc_q;
    assign out_data   = main_data_q;
    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = out_valid & out_ready;

    // Next-state and datapath selection; freeze needs no branch since both fires are masked.
    always_comb begin
        state_d      = state_q;
        main_pc_d    = main_pc_q;
        main_data_d  = main_data_q;
        main_valid_d = main_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            state_d      = EMPTY;
            main_pc_d    = PC_RESET;
            main_data_d  = NOP_DATA;
            main_valid_d = 1'b0;
            skid_pc_d    = PC_RESET;
            skid_data_d  = NOP_DATA;
            skid_valid_d = 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire_s) begin
                        state_d      = FULL;
                        main_pc_d    = in_pc;
                        main_data_d  = in_data;
                        main_valid_d = 1'b1;
                    end else begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (in_fire_s && out_fire_s) begin
                        state_d     = FULL;
                        main_pc_d   = in_pc;
                        main_data_d = in_data;
                    end else if (in_fire_s) begin
                        state_d      = SKID;
                        skid_pc_d    = in_pc;
                        skid_data_d  = in_data;
                        skid_valid_d = 1'b1;
                    end else if (out_fire_s) begin
                        state_d      = EMPTY;
                        main_valid_d = 1'b0;
                    end else begin
                        state_d = FULL;
                    end
                end
                SKID: begin
                    if (out_fire_s) begin
                        state_d      = FULL;
                        main_pc_d    = skid_pc_q;
                        main_data_d  = skid_data_q;
                        skid_valid_d = 1'b0;
                    end else begin
                        state_d = SKID;
                    end
                end
                default: begin
                    state_d      = EMPTY;
                    main_valid_d = 1'b0;
                    skid_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and storage registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= EMPTY;
            main_pc_q    <= PC_RESET;
            main_data_q  <= NOP_DATA;
            main_valid_q <= 1'b0;
            skid_pc_q    <= PC_RESET;
            skid_data_q  <= NOP_DATA;
            skid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            main_pc_q    <= main_pc_d;
            main_data_q  <= main_data_d;
            main_valid_q <= main_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    pipe_stage_stats #(
        .CNT_W(CNT_W)
    ) u_stats (
        .clk      (clk),
        .rst      (rst),
        .stall_inc(main_valid_q & (~out_ready | freeze)),
        .flush_inc(flush),
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a capacity-2 FIFO model predicts ready/valid and entry order.
module tb_pipe_stage_reg;

    localparam int unsigned DW  = 32;
    localparam int unsigned PW  = 32;
    localparam int unsigned CW  = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] PCR = 32'h0000_1000;

    logic          clk = 1'b0;
    logic          rst, freeze, flush, in_valid, in_ready, out_valid, out_ready;
    logic [PW-1:0] in_pc, out_pc;
    logic [DW-1:0] in_data, out_data;
`ifdef PIPE_STAGE_STATS_EN
    logic [CW-1:0] stall_cnt, flush_cnt;
`endif

    pipe_stage_reg #(
        .DATA_W(DW), .PC_W(PW), .NOP_DATA(NOP), .PC_RESET(PCR), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_data(out_data)
`ifdef PIPE_STAGE_STATS_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [63:0] exp_q[$];
    bit          mon_en = 1'b0;
    int          n_checks = 0;
    int          n_err = 0;
    int          n_out = 0;
    int          exp_stall = 0;
    int          exp_flush = 0;
    int          sat_max = (1 << CW) - 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; the accepted entry is pushed after the edge it fires on.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] d,
                        input logic ordy, input logic frz, input logic fl, input logic r);
        logic fire;
        in_valid  = v;
        in_pc     = pc;
        in_data   = d;
        out_ready = ordy;
        freeze    = frz;
        flush     = fl;
        rst       = r;
        fire      = r && !fl && !frz && v && (exp_q.size() < 2);
        @(posedge clk);
        #1;
        if (fire) exp_q.push_back({pc, d});
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, $urandom, $urandom, ordy, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: compare handshake and presented entry, then retire/clear per the model.
    always @(negedge clk) begin
        if (mon_en) begin
            logic main_v, exp_ov;
            main_v = (exp_q.size() > 0);
            exp_ov = main_v && !freeze;
            chk("in_ready", {63'd0, in_ready}, {63'd0, rst && !freeze && (exp_q.size() < 2)});
            chk("out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
            if (out_valid) begin
                if (main_v) begin
                    chk("out_entry", {out_pc, out_data}, exp_q[0]);
                end else begin
                    n_checks++;
                    n_err++;
                    $display("FAIL out_entry: got %0h expected no entry", {out_pc, out_data});
                end
            end
`ifdef PIPE_STAGE_STATS_EN
            chk("stall_cnt", {60'd0, stall_cnt}, 64'(exp_stall));
            chk("flush_cnt", {60'd0, flush_cnt}, 64'(exp_flush));
`endif
            if (!rst) begin
                exp_q.delete();
                exp_stall = 0;
                exp_flush = 0;
            end else begin
                if (main_v && (!out_ready || freeze) && exp_stall < sat_max) exp_stall++;
                if (flush && exp_flush < sat_max) exp_flush++;
                if (flush) begin
                    exp_q.delete();
                end else if (exp_ov && out_ready) begin
                    void'(exp_q.pop_front());
                    n_out++;
                end
            end
        end
    end

    initial begin
        int nxt, base;
        rst = 1'b0; freeze = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = 32'd0; in_data = 32'd0;

        // Reset
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_out_pc", {32'd0, out_pc}, {32'd0, PCR});
        chk("rst_out_data", {32'd0, out_data}, {32'd0, NOP});
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);

        // Single entry, 1-cycle latency
        step(1'b1, 32'h4, 32'hE3A0_1005, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("lat_out_valid", {63'd0, out_valid}, 64'd1);
        chk("lat_out_pc", {32'd0, out_pc}, 64'h4);
        chk("lat_out_data", {32'd0, out_data}, 64'hE3A0_1005);
        chk("lat_in_ready", {63'd0, in_ready}, 64'd1);
        idle(1'b1);

        // Back-to-back stream
        base = n_out;
        for (int i = 0; i < 5; i++) step(1'b1, 32'(i * 4), $urandom, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        chk("stream_count", 64'(n_out - base), 64'd5);

        // Stream with out_ready low for 3 cycles
        nxt = 0;
        base = n_out;
        for (int c = 0; c < 14; c++) begin
            logic f;
            f = (nxt < 5) && (exp_q.size() < 2);
            step(nxt < 5, 32'(nxt * 4), $urandom, !(c >= 2 && c < 5), 1'b0, 1'b0, 1'b1);
            if (f) nxt++;
            if (exp_q.size() == 2) chk("skid_in_ready", {63'd0, in_ready}, 64'd0);
        end
        chk("skid_stream_count", 64'(n_out - base), 64'd5);

        // Flush while in SKID; the flush-cycle input must vanish
        step(1'b1, 32'hA0, $urandom, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'hA4, $urandom, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'hDEAD, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_out_data", {32'd0, out_data}, {32'd0, NOP});
        chk("flush_out_pc", {32'd0, out_pc}, {32'd0, PCR});
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        idle(1'b1);
        idle(1'b1);

        // Freeze 4 cycles while FULL (fresh reset so the stall count starts at 0)
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hB0, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'hBEEF, $urandom, 1'b1, 1'b1, 1'b0, 1'b1);
            chk("frz_out_valid", {63'd0, out_valid}, 64'd0);
            chk("frz_in_ready", {63'd0, in_ready}, 64'd0);
        end
`ifdef PIPE_STAGE_STATS_EN
        chk("frz_stall_cnt", {60'd0, stall_cnt}, 64'd4);
`endif
        chk("frz_hold_pc", {32'd0, out_pc}, 64'hB0);
        idle(1'b1);
        idle(1'b1);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, $urandom & 32'hFFFF_FFFC, $urandom,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 31) == 0, 1'b1);
        end

        // Reset while in SKID
        step(1'b1, 32'hC0, $urandom, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 32'hC4, $urandom, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'hC8, $urandom, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'hCC, $urandom, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst2_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst2_out_pc", {32'd0, out_pc}, {32'd0, PCR});
        chk("rst2_out_data", {32'd0, out_data}, {32'd0, NOP});
        chk("rst2_in_ready", {63'd0, in_ready}, 64'd0);
        idle(1'b1);

        // Saturate flush_cnt and push past it
        for (int i = 0; i < sat_max + 4; i++) step(1'b1, $urandom, $urandom, 1'b1, 1'b0, 1'b1, 1'b1);
`ifdef PIPE_STAGE_STATS_EN
        chk("flush_cnt_sat", {60'd0, flush_cnt}, 64'(sat_max));
`endif

        // Drain with a bounded budget
        step(1'b1, 32'hE0, $urandom, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) idle(1'b1);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        idle(1'b1);
        mon_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register, successor to the fixed 32-bit IF/ID stage registers. Carries a PC plus an instruction/control payload between any two pipeline stages with a valid/ready handshake, freeze (stall) and flush (bubble injection). A two-entry skid buffer gives full throughput with a registered `in_ready`. Instantiated between IF/ID, ID/EXE, EXE/MEM and MEM/WB, each with its own widths.

## Interface
- `DATA_W`, 32: payload width (instruction or control/data bundle).
- `PC_W`, 32: PC field width.
- `NOP_DATA`, `{DATA_W{1'b0}}`: payload value loaded on reset and flush.
- `PC_RESET`, `{PC_W{1'b0}}`: PC value loaded on reset and flush.
- `CNT_W`, 16: statistics counter width; used only with `PIPE_STAGE_STATS_EN`.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `freeze`  in  1  stall: hold all state, block both handshakes.
- `flush`  in  1  discard all held entries and insert a bubble.
- `in_valid`  in  1  upstream entry valid.
- `in_ready`  out  1  stage can accept an entry.
- `in_pc`  in  PC_W  upstream PC.
- `in_data`  in  DATA_W  upstream payload.
- `out_valid`  out  1  downstream entry valid.
- `out_ready`  in  1  downstream accepts.
- `out_pc`  out  PC_W  registered PC.
- `out_data`  out  DATA_W  registered payload.
- `stall_cnt`  out  CNT_W  stall cycles (stats build only).
- `flush_cnt`  out  CNT_W  flushes (stats build only).

## Operation
- Storage: main register (drives outputs) and skid register, each PC, payload and valid.
- States: EMPTY (no entries), FULL (main only), SKID (main and skid).
- `in_fire = in_valid & in_ready`; `out_fire = out_valid & out_ready`.
- `in_ready = (state != SKID) & ~freeze`. `out_valid = main_valid & ~freeze`.
- Priority: `rst` low > `flush` > `freeze` > normal.
- EMPTY: `in_fire` → FULL, main ← input.
- FULL:
  - `in_fire & out_fire` → FULL, main ← input.
  - `in_fire & ~out_fire` → SKID, skid ← input.
  - `~in_fire & out_fire` → EMPTY.
  - Otherwise hold.
- SKID: `out_fire` → FULL, main ← skid. No input is accepted.
- Entries leave in arrival order. No entry is dropped or duplicated, except on flush.
- Flush: next state EMPTY; both valids 0; main and skid PC/payload ← `PC_RESET`/`NOP_DATA`. An input presented in the flush cycle is dropped, even if `in_ready` was high.
- Freeze: no register changes; outputs hold their previous values, with `out_valid` masked to 0.
- Reset values:
  - `out_valid` 0, `out_pc` `PC_RESET`, `out_data` `NOP_DATA`.
  - State EMPTY.
  - `in_ready` 0 while `rst` is low, 1 in the first cycle after release (if not frozen).
  - Counters 0.

## Timing
- Latency: 1 cycle from `in_fire` to `out_valid` (from EMPTY).
- Throughput: 1 entry/cycle while `out_ready` stays high.
- `in_ready` depends only on registered state and `freeze`. There is no combinational path from `out_ready`.
- Flush and reset take effect at the edge of the cycle they are sampled in. Both override freeze.
- Reset mid-transfer discards all entries; no partial state is kept.
- Simultaneous `flush` and `freeze`: the flush wins.

## Configuration
- `PIPE_STAGE_STATS_EN` defined: `stall_cnt` and `flush_cnt` ports and logic exist.
  - `stall_cnt` increments on each cycle with `main_valid & (~out_ready | freeze)`.
  - `flush_cnt` increments on each cycle with `flush` high.
  - Both saturate at all-ones. Both clear on reset only.
- Undefined: ports and counters are absent. Handshake behaviour is unchanged.

## Structure
- Shared package `pipe_pkg`:
  - state typedef `pipe_state_t` {EMPTY, FULL, SKID};
  - default NOP payload constant.
- Sub-module `pipe_stage_stats`: the saturating counter pair, instantiated only under `PIPE_STAGE_STATS_EN`.

## Test plan
- Reset, then `in_valid`=1 with PC 0x4 and data 0xE3A01005, `out_ready`=1: `out_valid` next cycle with the same values; `in_ready`=1 throughout.
- Back-to-back stream of PCs 0x0, 0x4, 0x8, 0xC, 0x10 with `out_ready`=1: one output per cycle, in order, 1-cycle latency.
- Drop `out_ready` for 3 cycles mid-stream: `in_ready` falls after the second held entry (SKID); no loss; order 0x8, 0xC resumes correctly.
- Assert `flush` while in SKID: next cycle `out_valid`=0, `out_data`=`NOP_DATA`, `in_ready`=1; the input in the flush cycle never appears.
- Hold `freeze` 4 cycles while FULL: `out_valid`=0 and `in_ready`=0; the held entry reappears unchanged after release. With stats, `stall_cnt`=4.
- Assert `rst` low while in SKID: all outputs return to reset values; `flush_cnt` at all-ones is held without wrap on a further flush (stats build).
